alu_arbiter: RTL and testbench

- Shares the single combinational RV32I ALU between two requesters: req0 is the main execute pipeline and req1 is the address/branch helper path.
- Arbitrates round-robin and drives the shared ALU operand/control inputs from the granted request.
- Registers the ALU result into a one-entry response stage, tagged with the requester ID, under valid/ready backpressure.
- Sits between issue logic and the ALU in the execute stage.

---
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters, with a one-entry tagged response stage.
// Optional per-requester grant and conflict counters when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
   parameter int XLEN       = 32,
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [6:0]      req0_opcode,
   input  logic [2:0]      req0_func3,
   input  logic [6:0]      req0_func7,
   input  logic [XLEN-1:0] req0_imm,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [6:0]      req1_opcode,
   input  logic [2:0]      req1_func3,
   input  logic [6:0]      req1_func7,
   input  logic [XLEN-1:0] req1_imm,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic [6:0]      alu_opcode,
   output logic [2:0]      alu_func3,
   output logic [6:0]      alu_func7,
   output logic [XLEN-1:0] alu_imm,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_result,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [XLEN-1:0] rsp_result
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]     stat_grant0,
   output logic [15:0]     stat_grant1,
   output logic [15:0]     stat_conflict
`endif
);
   logic prio;
   logic slot_free;
   logic grant0;
   logic grant1;
   logic xfer;
   always_comb begin
      slot_free = !rsp_valid || rsp_ready;
      grant0    = slot_free && req0_valid && (!req1_valid || !prio);
      grant1    = slot_free && req1_valid && (!req0_valid || prio);
      xfer      = grant0 || grant1;
      req0_ready = grant0;
      req1_ready = grant1;
   end
   // Ungranted cycles present opcode 0 so the shared ALU idles at zero.
   always_comb begin
      alu_opcode = grant0 ? req0_opcode : grant1 ? req1_opcode : '0;
      alu_func3  = grant0 ? req0_func3  : grant1 ? req1_func3  : '0;
      alu_func7  = grant0 ? req0_func7  : grant1 ? req1_func7  : '0;
      alu_imm    = grant0 ? req0_imm    : grant1 ? req1_imm    : '0;
      alu_a      = grant0 ? req0_a      : grant1 ? req1_a      : '0;
      alu_b      = grant0 ? req0_b      : grant1 ? req1_b      : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio       <= RESET_PRIO;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
      end else if (xfer) begin
         prio       <= grant0;
         rsp_valid  <= 1'b1;
         rsp_id     <= grant1;
         rsp_result <= alu_result;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
`ifdef ALU_ARB_STATS_EN
   logic conflict;
   assign conflict = req0_valid && req1_valid && slot_free;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grant0   <= '0;
         stat_grant1   <= '0;
         stat_conflict <= '0;
      end else begin
         stat_grant0   <= stat_grant0   + 16'((grant0   && stat_grant0   != 16'hFFFF) ? 1 : 0);
         stat_grant1   <= stat_grant1   + 16'((grant1   && stat_grant1   != 16'hFFFF) ? 1 : 0);
         stat_conflict <= stat_conflict + 16'((conflict && stat_conflict != 16'hFFFF) ? 1 : 0);
      end
   end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of grant, ALU drive, response stage, backpressure and reset for alu_arbiter.
// Covers the stats counters when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [6:0]  req0_opcode, req1_opcode, req0_func7, req1_func7;
   logic [2:0]  req0_func3, req1_func3;
   logic [31:0] req0_imm, req0_a, req0_b, req1_imm, req1_a, req1_b;
   logic [6:0]  alu_opcode, alu_func7;
   logic [2:0]  alu_func3;
   logic [31:0] alu_imm, alu_a, alu_b, alu_result;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   logic [31:0] opb;
   int          n_cmp = 0;
   int          n_err = 0;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif
   always #5 clk = ~clk;
   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_func3(req0_func3), .req0_func7(req0_func7), .req0_imm(req0_imm),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_func3(req1_func3), .req1_func7(req1_func7), .req1_imm(req1_imm),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func7(alu_func7),
      .alu_imm(alu_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
`ifdef ALU_ARB_STATS_EN
      , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
   );
   // Stand-in for the shared ALU: the RV32I subset this bench exercises.
   always_comb begin
      opb = (alu_opcode == 7'h13) ? alu_imm : alu_b;
      alu_result = '0;
      if (alu_opcode == 7'h33 || alu_opcode == 7'h13) begin
         case (alu_func3)
            3'd0:    alu_result = (alu_opcode == 7'h33 && alu_func7[5]) ? alu_a - opb : alu_a + opb;
            3'd4:    alu_result = alu_a ^ opb;
            3'd6:    alu_result = alu_a | opb;
            3'd7:    alu_result = alu_a & opb;
            default: alu_result = '0;
         endcase
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set0(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      req0_valid = v; req0_opcode = op; req0_func3 = f3; req0_func7 = 7'd0;
      req0_a = a; req0_b = b; req0_imm = imm;
   endtask
   task automatic set1(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      req1_valid = v; req1_opcode = op; req1_func3 = f3; req1_func7 = 7'd0;
      req1_a = a; req1_b = b; req1_imm = imm;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask
   initial begin
      set0(1'b0, 7'd0, 3'd0, 0, 0, 0);
      set1(1'b0, 7'd0, 3'd0, 0, 0, 0);
      rsp_ready = 1'b1;
      do_reset();
      check("reset rsp_valid", 32'(rsp_valid), 0);
      check("reset rsp_id", 32'(rsp_id), 0);
      check("reset rsp_result", rsp_result, 0);
      // Single requester ADD 5+7
      set0(1'b1, 7'h33, 3'd0, 5, 7, 0);
      #1;
      check("add req0_ready", 32'(req0_ready), 1);
      check("add alu_a", alu_a, 5);
      tick();
      set0(1'b0, 7'd0, 3'd0, 0, 0, 0);
      check("add rsp_valid", 32'(rsp_valid), 1);
      check("add rsp_id", 32'(rsp_id), 0);
      check("add rsp_result", rsp_result, 12);
      // Fairness from a fresh pointer
      do_reset();
      set0(1'b1, 7'h13, 3'd0, 1, 0, 1);
      set1(1'b1, 7'h13, 3'd4, 32'hF0, 0, 32'hFF);
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("fair%0d req0_ready", k), 32'(req0_ready), 32'(k % 2 == 0));
         check($sformatf("fair%0d req1_ready", k), 32'(req1_ready), 32'(k % 2 == 1));
         tick();
         check($sformatf("fair%0d rsp_id", k), 32'(rsp_id), 32'(k % 2));
         check($sformatf("fair%0d rsp_result", k), rsp_result, (k % 2 == 0) ? 32'd2 : 32'h0F);
      end
      set0(1'b0, 7'd0, 3'd0, 0, 0, 0);
      set1(1'b0, 7'd0, 3'd0, 0, 0, 0);
`ifdef ALU_ARB_STATS_EN
      check("stat_grant0 fair", 32'(stat_grant0), 2);
      check("stat_grant1 fair", 32'(stat_grant1), 2);
      check("stat_conflict fair", 32'(stat_conflict), 4);
`endif
      // Backpressure: response (id1, 0x0F) held while req1 waits
      rsp_ready = 1'b0;
      set1(1'b1, 7'h33, 3'd0, 3, 4, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp%0d req1_ready", k), 32'(req1_ready), 0);
         tick();
         check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 1);
         check($sformatf("bp%0d rsp_result", k), rsp_result, 32'h0F);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp release req1_ready", 32'(req1_ready), 1);
      tick();
      set1(1'b0, 7'd0, 3'd0, 0, 0, 0);
      check("bp release rsp_id", 32'(rsp_id), 1);
      check("bp release rsp_result", rsp_result, 7);
      // Idle: ALU inputs zeroed, stage drains, pointer still favours req0? no, last xfer was req1 so pointer=0
      for (int k = 0; k < 2; k++) begin
         #1;
         check($sformatf("idle%0d alu_opcode", k), 32'(alu_opcode), 0);
         check($sformatf("idle%0d alu_a|b|imm", k), alu_a | alu_b | alu_imm, 0);
         tick();
         check($sformatf("idle%0d rsp_valid", k), 32'(rsp_valid), 0);
      end
      set0(1'b1, 7'h33, 3'd0, 5, 7, 0);
      set1(1'b1, 7'h33, 3'd0, 3, 4, 0);
      #1;
      check("post-idle req0_ready", 32'(req0_ready), 1);
      check("post-idle req1_ready", 32'(req1_ready), 0);
      tick();
      check("post-idle rsp_result", rsp_result, 12);
      #1;
      check("post-idle next req1_ready", 32'(req1_ready), 1);
      tick();
      check("post-idle next rsp_result", rsp_result, 7);
      // Reset mid-operation: pointer is now 0 again, but verify reset restores it after a req0 grant
      #1;
      tick();
      check("pre-reset rsp_valid", 32'(rsp_valid), 1);
      rst_n = 1'b0;
      #1;
      check("async reset rsp_valid", 32'(rsp_valid), 0);
      check("async reset rsp_result", rsp_result, 0);
      check("async reset rsp_id", 32'(rsp_id), 0);
      tick();
      rst_n = 1'b1;
      #1;
      check("after reset req0_ready", 32'(req0_ready), 1);
      check("after reset req1_ready", 32'(req1_ready), 0);
      tick();
      check("after reset rsp_id", 32'(rsp_id), 0);
      check("after reset rsp_result", rsp_result, 12);
`ifdef ALU_ARB_STATS_EN
      set1(1'b0, 7'd0, 3'd0, 0, 0, 0);
      repeat (70000) @(posedge clk);
      #1;
      check("stat_grant0 saturate", 32'(stat_grant0), 32'hFFFF);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
